mult_div_unit: RTL

Parametrised multicycle multiply/divide unit with HI/LO result registers, serving the MIPS-style multicycle datapath. It executes MULT, MULTU, DIV and DIVU over WIDTH iterations under a start/done handshake. It also provides direct HI/LO writes (MTHI/MTLO) while idle. The control unit launches an operation and polls `busy`/`done`; the HI/LO outputs feed the register-file write-data mux.

---
 rtl/mult_div_unit_pkg.sv | 26 ++
 rtl/mult_div_unit_if.sv | 29 ++
 rtl/mult_div_unit_step.sv | 32 +++
 rtl/mult_div_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the control unit that drives it:
// operation encodings, FSM state encodings and small op-class decode helpers.
package mdu_defs;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit <-> multiply/divide unit handshake and HI/LO result bus.
interface mult_div_unit_if
  import mdu_defs::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_step.sv
// One iteration of the unsigned core: shift-add multiply step or restoring-divide step.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] q_out
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum     = rem_in + (q_in[0] ? {1'b0, operand} : '0);
    shifted = {rem_in[WIDTH-1:0], q_in[WIDTH-1]};
    rem_out = {1'b0, sum[WIDTH:1]};
    q_out   = {sum[0], q_in[WIDTH-1:1]};
    if (is_div) begin
      // Trial subtract: keep the difference only when the divisor fits.
      if (shifted >= {1'b0, operand}) begin
        rem_out = shifted - {1'b0, operand};
        q_out   = {q_in[WIDTH-2:0], 1'b1};
      end else begin
        rem_out = shifted;
        q_out   = {q_in[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit with HI/LO registers; operates on magnitudes
// for WIDTH cycles, then applies sign correction in a single FIX cycle.
module mult_div_unit
  import mdu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  mdu_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               div_op, neg_q, neg_r, dz_pend, done_r, div_zero_r;
  logic [WIDTH-1:0]   operand, q, q_nxt, hi_r, lo_r;
  logic [WIDTH:0]     rem, rem_nxt;
  logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic               sgn, accept, dz_start;

  assign sgn      = op_is_signed(bus.op);
  assign a_mag    = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag    = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  // The cycle after a divide-by-zero start only reports it; nothing new is taken.
  assign accept   = (state == ST_IDLE) && !dz_pend && bus.start;
  assign dz_start = accept && op_is_div(bus.op) && (bus.b == '0);

  assign prod_fix = neg_q ? -{rem[WIDTH-1:0], q} : {rem[WIDTH-1:0], q};
  assign quot_fix = neg_q ? -q : q;
  assign rem_fix  = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_op),
    .rem_in  (rem),
    .q_in    (q),
    .operand (operand),
    .rem_out (rem_nxt),
    .q_out   (q_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && !dz_start) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(1))    state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      div_op     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      dz_pend    <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      operand    <= '0;
      q          <= '0;
      rem        <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
    end else begin
      done_r  <= 1'b0;
      dz_pend <= 1'b0;
      if (dz_pend) begin
        done_r     <= 1'b1;
        div_zero_r <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            div_zero_r <= 1'b0;
            if (dz_start) begin
              dz_pend <= 1'b1;
            end else begin
              div_op  <= op_is_div(bus.op);
              neg_q   <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_r   <= sgn && bus.a[WIDTH-1];
              // Multiply walks the multiplier through q; divide walks the dividend.
              operand <= op_is_div(bus.op) ? b_mag : a_mag;
              q       <= op_is_div(bus.op) ? a_mag : b_mag;
              rem     <= '0;
              cnt     <= CNT_W'(WIDTH);
            end
          end else if (!dz_pend) begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        ST_RUN: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          cnt <= cnt - CNT_W'(1);
        end
        ST_FIX: begin
          done_r <= 1'b1;
          if (div_op) begin
            lo_r <= quot_fix;
            hi_r <= rem_fix;
          end else begin
            {hi_r, lo_r} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
endmodule
